seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have parameter SIGNED, default 0, meaning 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start_n, input, 1, active-low start request, level-sampled at clk edges.
REQ-006 SHALL have port dividend, input, WIDTH, dividend operand, captured on an accepted start.
REQ-007 SHALL have port divisor, input, WIDTH, divisor operand, captured on an accepted start.
REQ-008 SHALL have port quotient, output, WIDTH, registered quotient.
REQ-009 SHALL have port remainder, output, WIDTH, registered remainder.
REQ-010 SHALL have port busy, output, 1, high while a division is in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when quotient/remainder are updated.
REQ-012 SHALL have port DVZ, output, 1, divide-by-zero error flag, held.
REQ-013 SHALL have port ovf, output, 1, signed overflow flag (most-negative / -1), valid with done.

Function
REQ-014 SHALL implement states IDLE, COUNT, FIX, ERROR; all outputs registered.
REQ-015 In IDLE or ERROR, start_n==0 with divisor!=0 SHALL capture operands, clear DVZ, and go to COUNT with the iteration counter cleared.
REQ-016 In IDLE, start_n==0 with divisor==0 SHALL go to ERROR and set DVZ=1; quotient and remainder SHALL keep their previous values.
REQ-017 In ERROR, DVZ SHALL stay 1 until an accepted start (REQ-015); start_n==0 with divisor==0 SHALL leave the block in ERROR.
REQ-018 When SIGNED=1, the block SHALL capture operand magnitudes and latch quotient sign = sign(dividend) XOR sign(divisor), and remainder sign = sign(dividend).
REQ-019 In COUNT, each cycle SHALL perform one restoring step: shift partial remainder left 1 with next dividend MSB; trial = partial - |divisor| at WIDTH+1 bits; if trial is non-negative, keep trial and shift 1 into the quotient, else restore and shift 0.
REQ-020 COUNT SHALL last exactly WIDTH cycles (counter width clog2(WIDTH)); after the WIDTH-th step the block SHALL go to FIX.
REQ-021 In FIX, the block SHALL write quotient/remainder (negated per REQ-018 when SIGNED=1), pulse done for one cycle, and return to IDLE.
REQ-022 Latency: start accepted at edge 0 -> done=1 and new results visible after edge WIDTH+1.
REQ-023 busy SHALL be 1 in COUNT and FIX, else 0; start_n SHALL be ignored while busy=1.
REQ-024 ovf SHALL be 1 only when SIGNED=1, dividend = most-negative value and divisor = -1; the quotient SHALL then be the WIDTH-bit truncation (most-negative value) and the remainder 0.
REQ-025 ovf SHALL update only in FIX and hold until the next FIX.
REQ-026 A start_n held low across done SHALL start a new division on the first IDLE edge (back-to-back permitted, one idle cycle).

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, quotient=0, remainder=0, busy=0, done=0, DVZ=0, ovf=0, regardless of clk.
REQ-028 Reset asserted mid-COUNT or FIX SHALL abort the operation with no done pulse; the first start after release behaves as from power-up.

Verification
REQ-029 WIDTH=8, SIGNED=0: start with 200/7 -> busy for 9 cycles, done pulse after edge 9, quotient=28, remainder=4, DVZ=0.
REQ-030 WIDTH=8, SIGNED=1: -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF); then -128/-1 -> quotient=0x80, remainder=0, ovf=1.
REQ-031 start with divisor=0 -> DVZ=1 next edge, no done, outputs unchanged; repeat with 0 -> stays ERROR; then 15/4 -> DVZ=0, done later with quotient=3, remainder=3.
REQ-032 Pulse start_n low again during COUNT with different operands -> ignored; result matches the first operands.
REQ-033 Assert rst at COUNT step 4 -> all outputs 0 asynchronously, no done; a fresh 255/255 then gives quotient=1, remainder=0.
REQ-034 WIDTH=16, SIGNED=0: 65535/1 -> quotient=0xFFFF, remainder=0, done after edge 17.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring divider, one quotient bit per clock.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//   SIGNED 0 = unsigned operands, 1 = two's-complement operands
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start_n    active-low start request, sampled at clk edges while not busy
//   dividend   dividend operand, captured on an accepted start
//   divisor    divisor operand, captured on an accepted start
//   quotient   registered quotient
//   remainder  registered remainder
//   busy       high while a division is in progress (COUNT and FIX)
//   done       one-cycle pulse when quotient/remainder are updated
//   DVZ        divide-by-zero flag, held until the next accepted start
//   ovf        signed overflow flag (most-negative / -1), updated with done
//
// State table:
//   state | meaning
//   IDLE  | waiting for start_n low
//   COUNT | WIDTH restoring steps, one per cycle
//   FIX   | apply result signs, publish results, pulse done
//   ERROR | last start had a zero divisor; DVZ held high
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_n,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             DVZ,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COUNT, FIX, ERROR} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // dq shifts the dividend out of its MSB while quotient bits enter at the LSB
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             ovf_case;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    dividend_neg = (SIGNED != 0) && dividend[WIDTH-1];
    divisor_neg  = (SIGNED != 0) && divisor[WIDTH-1];
    // magnitude of the most-negative value is 2^(WIDTH-1), still fits unsigned
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg  ? (~divisor + 1'b1)  : divisor;
    ovf_case     = (SIGNED != 0) &&
                   (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (&divisor);
    shifted      = {part, dq[WIDTH-1]};
    // trial[WIDTH] set means the subtraction went negative -> restore
    trial        = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dq        <= '0;
      part      <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      DVZ       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (!start_n) begin
            if (divisor != '0) begin
              dq       <= dividend_mag;
              dvs      <= divisor_mag;
              part     <= '0;
              cnt      <= '0;
              q_neg    <= dividend_neg ^ divisor_neg;
              r_neg    <= dividend_neg;
              ovf_pend <= ovf_case;
              DVZ      <= 1'b0;
              busy     <= 1'b1;
              state    <= COUNT;
            end else begin
              DVZ   <= 1'b1;
              state <= ERROR;
            end
          end
        end
        COUNT: begin
          dq <= {dq[WIDTH-2:0], ~trial[WIDTH]};
          if (!trial[WIDTH]) part <= trial[WIDTH-1:0];
          else               part <= shifted[WIDTH-1:0];
          if (cnt == CW'(WIDTH-1)) state <= FIX;
          else                     cnt   <= cnt + 1'b1;
        end
        FIX: begin
          quotient  <= q_neg ? (~dq + 1'b1)   : dq;
          remainder <= r_neg ? (~part + 1'b1) : part;
          ovf       <= ovf_pend;
          done      <= 1'b1;
          busy      <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: three instances (8-bit unsigned,
// 8-bit signed, 16-bit unsigned) driven through one shared stimulus path.
`timescale 1ns/1ps
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_g;
  int          sel;
  logic [31:0] op_a, op_b;

  logic sn0, sn1, sn2;
  assign sn0 = (sel == 0) ? start_g : 1'b1;
  assign sn1 = (sel == 1) ? start_g : 1'b1;
  assign sn2 = (sel == 2) ? start_g : 1'b1;

  logic [7:0]  q0, r0, q1, r1;
  logic [15:0] q2, r2;
  logic        b0, d0, z0, o0, b1, d1, z1, o1, b2, d2, z2, o2;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .start_n(sn0), .dividend(op_a[7:0]), .divisor(op_b[7:0]),
    .quotient(q0), .remainder(r0), .busy(b0), .done(d0), .DVZ(z0), .ovf(o0));

  seq_divider #(.WIDTH(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .start_n(sn1), .dividend(op_a[7:0]), .divisor(op_b[7:0]),
    .quotient(q1), .remainder(r1), .busy(b1), .done(d1), .DVZ(z1), .ovf(o1));

  seq_divider #(.WIDTH(16), .SIGNED(0)) u_u16 (
    .clk(clk), .rst(rst), .start_n(sn2), .dividend(op_a[15:0]), .divisor(op_b[15:0]),
    .quotient(q2), .remainder(r2), .busy(b2), .done(d2), .DVZ(z2), .ovf(o2));

  logic [31:0] obs_q, obs_r;
  logic        obs_busy, obs_done, obs_dvz, obs_ovf;

  always_comb begin
    obs_q = '0; obs_r = '0; obs_busy = 1'b0; obs_done = 1'b0; obs_dvz = 1'b0; obs_ovf = 1'b0;
    case (sel)
      0: begin obs_q = {24'b0, q0}; obs_r = {24'b0, r0}; obs_busy = b0; obs_done = d0; obs_dvz = z0; obs_ovf = o0; end
      1: begin obs_q = {24'b0, q1}; obs_r = {24'b0, r1}; obs_busy = b1; obs_done = d1; obs_dvz = z1; obs_ovf = o1; end
      2: begin obs_q = {16'b0, q2}; obs_r = {16'b0, r2}; obs_busy = b2; obs_done = d2; obs_dvz = z2; obs_ovf = o2; end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended operands, truncated to w bits.
  function automatic void model(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic ov);
    longint m, sa, sb, sq, sr;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sg && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sg && sb[w-1]) sb = sb - (longint'(1) << w);
    ov = sg && (sa == -(longint'(1) << (w-1))) && (sb == -1);
    sq = sa / sb;
    sr = sa % sb;
    q  = 32'(sq & m);
    r  = 32'(sr & m);
  endfunction

  task automatic run_div(input int s, input logic [31:0] a, input logic [31:0] b, input bit poke,
                         output logic [31:0] q, output logic [31:0] r, output logic ov,
                         output int lat, output int bcnt);
    @(negedge clk);
    sel = s; op_a = a; op_b = b; start_g = 1'b0;
    @(posedge clk); #1;
    bcnt = int'(obs_busy);
    @(negedge clk);
    start_g = 1'b1;
    lat = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (poke && k == 3) begin op_a = ~a; op_b = 32'd3; start_g = 1'b0; end
      if (poke && k == 4) start_g = 1'b1;
      bcnt += int'(obs_busy);
      if (obs_done) begin lat = k; break; end
    end
    q = obs_q; r = obs_r; ov = obs_ovf;
  endtask

  task automatic do_check(input string nm, input int s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic eov, input bit poke);
    logic [31:0] q, r;
    logic        ov;
    int          lat, bc, w;
    w = (s == 2) ? 16 : 8;
    run_div(s, a, b, poke, q, r, ov, lat, bc);
    chk({nm, "_quot"}, q, eq);
    chk({nm, "_rem"}, r, er);
    chk({nm, "_ovf"}, {31'b0, ov}, {31'b0, eov});
    chk({nm, "_latency"}, 32'(lat), 32'(w + 1));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(w + 1));
  endtask

  typedef struct {
    int          s;
    logic [31:0] a, b, q, r;
    logic        ov;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] eq, er, qa, ra, a, b, m;
    logic        eov, seen, busy10;
    int          first, second, w, s;

    tbl[0]  = '{0, 200,    7,    28,     4,    1'b0};
    tbl[1]  = '{0, 15,     4,    3,      3,    1'b0};
    tbl[2]  = '{0, 255,    255,  1,      0,    1'b0};
    tbl[3]  = '{0, 0,      5,    0,      0,    1'b0};
    tbl[4]  = '{0, 255,    1,    255,    0,    1'b0};
    tbl[5]  = '{0, 7,      200,  0,      7,    1'b0};
    tbl[6]  = '{1, 'hF9,   2,    'hFD,   'hFF, 1'b0};
    tbl[7]  = '{1, 'h80,   'hFF, 'h80,   0,    1'b1};
    tbl[8]  = '{1, 7,      'hFE, 'hFD,   1,    1'b0};
    tbl[9]  = '{1, 'h80,   1,    'h80,   0,    1'b0};
    tbl[10] = '{1, 'h7F,   'h80, 0,      'h7F, 1'b0};
    tbl[11] = '{2, 'hFFFF, 1,    'hFFFF, 0,    1'b0};
    tbl[12] = '{2, 1000,   7,    142,    6,    1'b0};

    rst = 1'b1; start_g = 1'b1; sel = 0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      chk($sformatf("reset_quot_%0d", i), obs_q, 0);
      chk($sformatf("reset_rem_%0d", i), obs_r, 0);
      chk($sformatf("reset_flags_%0d", i), {28'b0, obs_busy, obs_done, obs_dvz, obs_ovf}, 0);
    end
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_check($sformatf("table%0d", i), tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].ov, 1'b0);

    // divide by zero: flag next edge, results untouched, ERROR sticky, then recover
    do_check("pre_dvz", 0, 200, 7, 28, 4, 1'b0, 1'b0);
    @(negedge clk); sel = 0; op_a = 9; op_b = 0; start_g = 1'b0;
    @(posedge clk); #1;
    chk("dvz_set", {31'b0, obs_dvz}, 1);
    chk("dvz_no_done", {30'b0, obs_done, obs_busy}, 0);
    chk("dvz_quot_kept", obs_q, 28);
    chk("dvz_rem_kept", obs_r, 4);
    @(posedge clk); #1;
    chk("dvz_repeat", {31'b0, obs_dvz}, 1);
    @(negedge clk); start_g = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("dvz_held", {31'b0, obs_dvz}, 1);
    do_check("dvz_recover", 0, 15, 4, 3, 3, 1'b0, 1'b0);
    chk("dvz_cleared", {31'b0, obs_dvz}, 0);

    // start pulse during COUNT must be ignored
    do_check("ignore_busy", 0, 200, 7, 28, 4, 1'b0, 1'b1);

    // reset at COUNT step 4
    @(negedge clk); sel = 0; op_a = 15; op_b = 4; start_g = 1'b0;
    @(posedge clk);
    @(negedge clk); start_g = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_quot", obs_q, 0);
    chk("abort_rem", obs_r, 0);
    chk("abort_flags", {28'b0, obs_busy, obs_done, obs_dvz, obs_ovf}, 0);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= obs_done; end
    @(negedge clk); rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; seen |= obs_done; end
    chk("abort_no_done", {31'b0, seen}, 0);
    do_check("after_abort", 0, 255, 255, 1, 0, 1'b0, 1'b0);

    // back-to-back: start_n held low across done
    @(negedge clk); sel = 0; op_a = 15; op_b = 4; start_g = 1'b0;
    @(posedge clk); #1;
    op_a = 200; op_b = 7;
    first = 0; second = 0; busy10 = 1'b0; qa = '0; ra = '0; eq = '0; er = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin busy10 = obs_busy; start_g = 1'b1; end
      if (obs_done) begin
        if (first == 0) begin first = k; qa = obs_q; ra = obs_r; end
        else if (second == 0) begin second = k; eq = obs_q; er = obs_r; end
      end
    end
    chk("b2b_first_latency", 32'(first), 9);
    chk("b2b_first_quot", qa, 3);
    chk("b2b_first_rem", ra, 3);
    chk("b2b_restart_busy", {31'b0, busy10}, 1);
    chk("b2b_second_latency", 32'(second), 19);
    chk("b2b_second_quot", eq, 28);
    chk("b2b_second_rem", er, 4);

    // randomized operands against the integer reference
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 2));
      w = (s == 2) ? 16 : 8;
      m = (32'd1 << w) - 1;
      a = $urandom & m;
      b = $urandom & m;
      if (s == 1 && $urandom_range(0, 7) == 0) begin a = 32'h80; b = 32'hFF; end
      if (s == 1 && $urandom_range(0, 7) == 0) b = 32'hFF;
      if (b == 0) b = 1;
      model(w, s == 1, a, b, eq, er, eov);
      do_check($sformatf("rand%0d_s%0d_%0h_%0h", i, s, a, b), s, a, b, eq, er, eov, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
